// File: rtl/vec_register_file_sb.sv
// Vector register file with masked write port, same-cycle write-to-read bypass and a busy scoreboard.
// Optional build macro VRF_ZERO_REG_EN makes register 0 a hardwired zero.
module vec_register_file_sb #(
  parameter  int DATA_W    = 8,
  parameter  int LANES     = 4,
  parameter  int REG_COUNT = 8,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_sel,
  input  logic [LANES-1:0]        wr_mask,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_sel,
  input  logic [ADDR_W-1:0]       rd_sel1,
  input  logic [ADDR_W-1:0]       rd_sel2,
  input  logic                    rd_en1,
  input  logic                    rd_en2,
  output logic [LANES*DATA_W-1:0] rd_data1,
  output logic [LANES*DATA_W-1:0] rd_data2,
  output logic [REG_COUNT-1:0]    busy,
  output logic                    hazard
);

  localparam int VEC_W = LANES * DATA_W;
`ifdef VRF_ZERO_REG_EN
  localparam int FIRST_REG = 1;
`else
  localparam int FIRST_REG = 0;
`endif

  logic [VEC_W-1:0]     mem_r [REG_COUNT];
  logic [REG_COUNT-1:0] busy_r;
  logic [VEC_W-1:0]     byp1_s;
  logic [VEC_W-1:0]     byp2_s;
  logic                 rd_ok1_s;
  logic                 rd_ok2_s;
  logic                 hit1_s;
  logic                 hit2_s;
  logic                 haz1_s;
  logic                 haz2_s;

  // Register 0 is excluded when it is the hardwired zero register.
  function automatic logic sel_ok(input logic [ADDR_W-1:0] sel);
    return (int'(sel) >= FIRST_REG) && (int'(sel) < REG_COUNT);
  endfunction

  // Lane storage: cleared on reset, masked lanes written on writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        mem_r[r] <= '0;
      end
    end else if (wr_en) begin
      for (int r = FIRST_REG; r < REG_COUNT; r++) begin
        for (int l = 0; l < LANES; l++) begin
          if ((wr_sel == ADDR_W'(r)) && wr_mask[l]) begin
            mem_r[r][l*DATA_W +: DATA_W] <= wr_data[l*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Scoreboard: a new issue outranks a writeback to the same register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_r <= '0;
    end else begin
      for (int r = FIRST_REG; r < REG_COUNT; r++) begin
        if (iss_en && (iss_sel == ADDR_W'(r))) begin
          busy_r[r] <= 1'b1;
        end else if (wr_en && (wr_sel == ADDR_W'(r))) begin
          busy_r[r] <= 1'b0;
        end
      end
    end
  end

  // Select qualification, bypass hit detection and per-port hazard terms.
  always_comb begin
    rd_ok1_s = sel_ok(rd_sel1);
    rd_ok2_s = sel_ok(rd_sel2);
    hit1_s   = wr_en && (wr_sel == rd_sel1);
    hit2_s   = wr_en && (wr_sel == rd_sel2);
    haz1_s   = rd_en1 && rd_ok1_s && busy_r[rd_sel1] && !hit1_s;
    haz2_s   = rd_en2 && rd_ok2_s && busy_r[rd_sel2] && !hit2_s;
  end

  // Merge in-flight writeback lanes over the stored vector.
  always_comb begin
    byp1_s = mem_r[rd_sel1];
    byp2_s = mem_r[rd_sel2];
    for (int l = 0; l < LANES; l++) begin
      byp1_s[l*DATA_W +: DATA_W] = (hit1_s && wr_mask[l]) ? wr_data[l*DATA_W +: DATA_W]
                                                          : mem_r[rd_sel1][l*DATA_W +: DATA_W];
      byp2_s[l*DATA_W +: DATA_W] = (hit2_s && wr_mask[l]) ? wr_data[l*DATA_W +: DATA_W]
                                                          : mem_r[rd_sel2][l*DATA_W +: DATA_W];
    end
  end

  // Read outputs and hazard are held at zero while reset is asserted.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    hazard   = 1'b0;
    if (reset) begin
      rd_data1 = rd_ok1_s ? byp1_s : '0;
      rd_data2 = rd_ok2_s ? byp2_s : '0;
      hazard   = haz1_s || haz2_s;
    end else begin
      rd_data1 = '0;
      rd_data2 = '0;
      hazard   = 1'b0;
    end
  end

  assign busy = busy_r;

endmodule

// File: tb/tb_vec_register_file_sb.sv
// Table-driven bench for vec_register_file_sb: each row's expected outputs go through a
// scoreboard queue and are compared mid-cycle, followed by a post-reset readback sweep.
module tb_vec_register_file_sb;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [2:0]  iss_sel;
  logic [2:0]  rd_sel1;
  logic [2:0]  rd_sel2;
  logic        rd_en1;
  logic        rd_en2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [7:0]  busy;
  logic        hazard;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rst; logic we; logic [2:0] ws; logic [3:0] wm; logic [31:0] wd;
    logic ie; logic [2:0] isel; logic [2:0] r1; logic [2:0] r2; logic e1; logic e2;
    logic [31:0] x1; logic [31:0] x2; logic [7:0] xb; logic xh;
  } vec_t;

  typedef struct {
    logic [31:0] d1; logic [31:0] d2; logic [7:0] b; logic h; int idx;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[28];

  vec_register_file_sb #(.DATA_W(8), .LANES(4), .REG_COUNT(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_mask(wr_mask),
    .wr_data(wr_data), .iss_en(iss_en), .iss_sel(iss_sel), .rd_sel1(rd_sel1),
    .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_data1(rd_data1),
    .rd_data2(rd_data2), .busy(busy), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, queue its expectation, and score it mid-cycle.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    reset = v.rst; wr_en = v.we; wr_sel = v.ws; wr_mask = v.wm; wr_data = v.wd;
    iss_en = v.ie; iss_sel = v.isel; rd_sel1 = v.r1; rd_sel2 = v.r2;
    rd_en1 = v.e1; rd_en2 = v.e2;
    exp_q.push_back('{v.x1, v.x2, v.xb, v.xh, idx});
    #2;
    e = exp_q.pop_front();
    check("rd_data1", e.idx, rd_data1, e.d1);
    check("rd_data2", e.idx, rd_data2, e.d2);
    check("busy",     e.idx, {24'd0, busy}, {24'd0, e.b});
    check("hazard",   e.idx, {31'd0, hazard}, {31'd0, e.h});
  endtask

  initial begin
    vec_t v;
    //           rst  we   ws    wm    wd            ie   is    r1    r2    e1   e2   x1            x2            busy   hz
    tbl[0]  = '{1'b1,1'b1,3'd1,4'hF,32'h11111111,1'b1,3'd7,3'd1,3'd0,1'b0,1'b0,32'h11111111,32'h00000000,8'h00,1'b0};
    tbl[1]  = '{1'b1,1'b1,3'd3,4'hF,32'hA5A5A5A5,1'b0,3'd0,3'd1,3'd7,1'b1,1'b1,32'h11111111,32'h00000000,8'h80,1'b1};
    tbl[2]  = '{1'b0,1'b1,3'd2,4'hF,32'hFFFFFFFF,1'b1,3'd2,3'd3,3'd1,1'b1,1'b1,32'h00000000,32'h00000000,8'h80,1'b0};
    tbl[3]  = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd3,3'd2,1'b1,1'b1,32'h00000000,32'h00000000,8'h00,1'b0};
    tbl[4]  = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd1,3'd7,1'b1,1'b1,32'h00000000,32'h00000000,8'h00,1'b0};
    tbl[5]  = '{1'b1,1'b1,3'd3,4'hF,32'h44332211,1'b0,3'd0,3'd0,3'd0,1'b0,1'b0,32'h00000000,32'h00000000,8'h00,1'b0};
    tbl[6]  = '{1'b1,1'b1,3'd3,4'h5,32'hAABBCCDD,1'b0,3'd0,3'd3,3'd3,1'b0,1'b0,32'h44BB22DD,32'h44BB22DD,8'h00,1'b0};
    tbl[7]  = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd3,3'd3,1'b0,1'b0,32'h44BB22DD,32'h44BB22DD,8'h00,1'b0};
    tbl[8]  = '{1'b1,1'b1,3'd5,4'hF,32'hFFFFFFFF,1'b0,3'd0,3'd3,3'd5,1'b0,1'b0,32'h44BB22DD,32'hFFFFFFFF,8'h00,1'b0};
    tbl[9]  = '{1'b1,1'b1,3'd5,4'h3,32'h12345678,1'b0,3'd0,3'd5,3'd3,1'b0,1'b0,32'hFFFF5678,32'h44BB22DD,8'h00,1'b0};
    tbl[10] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd5,3'd5,1'b0,1'b0,32'hFFFF5678,32'hFFFF5678,8'h00,1'b0};
    tbl[11] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b1,3'd2,3'd2,3'd2,1'b0,1'b1,32'h00000000,32'h00000000,8'h00,1'b0};
    tbl[12] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd0,3'd2,1'b0,1'b1,32'h00000000,32'h00000000,8'h04,1'b1};
    tbl[13] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd0,3'd2,1'b0,1'b0,32'h00000000,32'h00000000,8'h04,1'b0};
    tbl[14] = '{1'b1,1'b1,3'd2,4'h0,32'hDEADBEEF,1'b0,3'd0,3'd0,3'd2,1'b0,1'b1,32'h00000000,32'h00000000,8'h04,1'b0};
    tbl[15] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd0,3'd2,1'b0,1'b1,32'h00000000,32'h00000000,8'h00,1'b0};
    tbl[16] = '{1'b1,1'b1,3'd6,4'hF,32'h66666666,1'b1,3'd6,3'd6,3'd3,1'b1,1'b0,32'h66666666,32'h44BB22DD,8'h00,1'b0};
    tbl[17] = '{1'b1,1'b1,3'd4,4'hF,32'h04040404,1'b1,3'd1,3'd6,3'd4,1'b1,1'b0,32'h66666666,32'h04040404,8'h40,1'b1};
    tbl[18] = '{1'b1,1'b1,3'd6,4'h1,32'h000000AB,1'b1,3'd6,3'd6,3'd1,1'b1,1'b1,32'h666666AB,32'h00000000,8'h42,1'b1};
    tbl[19] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd6,3'd4,1'b1,1'b1,32'h666666AB,32'h04040404,8'h42,1'b1};
    tbl[20] = '{1'b1,1'b1,3'd1,4'hF,32'h01010101,1'b0,3'd0,3'd1,3'd6,1'b1,1'b0,32'h01010101,32'h666666AB,8'h42,1'b0};
    tbl[21] = '{1'b1,1'b1,3'd6,4'hF,32'h06060606,1'b0,3'd0,3'd6,3'd1,1'b1,1'b1,32'h06060606,32'h01010101,8'h40,1'b0};
    tbl[22] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd6,3'd6,1'b1,1'b1,32'h06060606,32'h06060606,8'h00,1'b0};
    tbl[23] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b1,3'd3,3'd0,3'd0,1'b0,1'b0,32'h00000000,32'h00000000,8'h00,1'b0};
    tbl[24] = '{1'b0,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd3,3'd6,1'b1,1'b0,32'h00000000,32'h00000000,8'h08,1'b0};
    tbl[25] = '{1'b1,1'b1,3'd3,4'hF,32'h33333333,1'b0,3'd0,3'd3,3'd6,1'b1,1'b0,32'h33333333,32'h00000000,8'h00,1'b0};
`ifdef VRF_ZERO_REG_EN
    tbl[26] = '{1'b1,1'b1,3'd0,4'hF,32'hDEADBEEF,1'b1,3'd0,3'd0,3'd0,1'b1,1'b0,32'h00000000,32'h00000000,8'h00,1'b0};
    tbl[27] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd0,3'd0,1'b1,1'b0,32'h00000000,32'h00000000,8'h00,1'b0};
`else
    tbl[26] = '{1'b1,1'b1,3'd0,4'hF,32'hDEADBEEF,1'b1,3'd0,3'd0,3'd0,1'b1,1'b0,32'hDEADBEEF,32'hDEADBEEF,8'h00,1'b0};
    tbl[27] = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'd0,3'd0,1'b1,1'b0,32'hDEADBEEF,32'hDEADBEEF,8'h01,1'b1};
`endif

    reset = 1'b0; wr_en = 1'b0; wr_sel = 3'd0; wr_mask = 4'h0; wr_data = 32'd0;
    iss_en = 1'b0; iss_sel = 3'd0; rd_sel1 = 3'd0; rd_sel2 = 3'd0; rd_en1 = 1'b0; rd_en2 = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i], i);
    end

    // Reset after activity, with a write and issue offered during reset that must be ignored.
    v = '{1'b0,1'b1,3'd4,4'hF,32'hCAFEF00D,1'b1,3'd5,3'd1,3'd3,1'b1,1'b1,
          32'h00000000,32'h00000000,8'h00,1'b0};
`ifndef VRF_ZERO_REG_EN
    v.xb = 8'h01;
`endif
    apply(v, 100);

    // Readback sweep: every register reads zero on both ports and nothing is busy.
    for (int s = 0; s < 8; s++) begin
      v = '{1'b1,1'b0,3'd0,4'h0,32'h00000000,1'b0,3'd0,3'(s),3'(7 - s),1'b1,1'b1,
            32'h00000000,32'h00000000,8'h00,1'b0};
      apply(v, 200 + s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_register_file_sb.md
Name: vec_register_file_sb

Overview:
- Parametrised vector register file for the ASIP decode stage: REG_COUNT registers, each LANES lanes of DATA_W bits.
- Two combinational read ports and one write port.
- Per-lane write mask and same-cycle write-to-read bypass.
- Per-register busy scoreboard (set at issue, cleared at writeback) that raises a read-hazard flag to the stall logic.

Parameters:
- DATA_W, 8, bits per lane
- LANES, 4, lanes per vector register
- REG_COUNT, 8, number of vector registers (>=2, need not be a power of two)
- ADDR_W, $clog2(REG_COUNT), register select width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-low reset
- wr_en  input  1  write-back strobe
- wr_sel  input  ADDR_W  destination register
- wr_mask  input  LANES  per-lane write enable
- wr_data  input  LANES*DATA_W  lane l at bits [l*DATA_W +: DATA_W]
- iss_en  input  1  instruction issued with a vector destination
- iss_sel  input  ADDR_W  issued destination register
- rd_sel1  input  ADDR_W  read port 1 select
- rd_sel2  input  ADDR_W  read port 2 select
- rd_en1  input  1  port 1 operand used (qualifies hazard)
- rd_en2  input  1  port 2 operand used (qualifies hazard)
- rd_data1  output  LANES*DATA_W  port 1 data, same lane packing
- rd_data2  output  LANES*DATA_W  port 2 data
- busy  output  REG_COUNT  scoreboard bit per register
- hazard  output  1  a used operand is pending

Behaviour:
- Clocking:
  - Single clock, no gated clocks.
  - All state updates at the rising edge of clk, qualified by enables.
- Reset:
  - When reset=0 at an edge, all storage lanes and all busy bits are cleared to 0.
  - Write and issue are ignored on that edge.
  - While reset=0, rd_data1, rd_data2 and hazard are forced to 0.
- Write:
  - At an edge with reset=1 and wr_en=1, for each l with wr_mask[l]=1: reg[wr_sel].lane[l] <= wr_data lane l.
  - Unmasked lanes hold their value.
  - wr_mask=0 still counts as a writeback for the scoreboard.
- Read:
  - Combinational, zero latency.
  - Bypass: if wr_en=1 and wr_sel==rd_selN, lanes with wr_mask=1 return the wr_data lane; other lanes return stored data.
  - Both ports may select the same register; they return identical data.
- Scoreboard, next-state per register r:
  - iss_en and iss_sel==r -> busy[r] <= 1.
  - else wr_en and wr_sel==r -> busy[r] <= 0.
  - else hold.
  - Issue and writeback to the same register in the same cycle leaves busy=1 (the new producer wins).
- Hazard:
  - hazard = (rd_en1 & busy[rd_sel1] & ~(wr_en & wr_sel==rd_sel1)) | (the same term for port 2).
  - A register being written this cycle is not a hazard, because it is bypassed.
  - An issue in the current cycle does not affect hazard until the next cycle.
- Out-of-range select (value >= REG_COUNT):
  - Writes are ignored.
  - Issue sets nothing.
  - Reads return 0 and contribute no hazard.
- Mid-operation reset clears pending busy bits; in-flight writebacks after reset are accepted as normal writes.

Optional Feature:
- Macro: VRF_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired zero: writes to it are discarded and reads (including bypass) return 0.
  - busy[0] is constant 0 and never contributes to hazard.
- Undefined: register 0 is an ordinary register.

Test Plan (DATA_W=8, LANES=4, REG_COUNT=8):
- Reset and readback: drive reset=0 for one edge after random writes, release -> rd_data1 = rd_data2 = 0 and busy=8'h00 for every rd_sel.
- Masked write: write reg3 = 32'h44332211 with mask 4'hF, then 32'hAABBCCDD with mask 4'b0101, read reg3 -> 32'h44BB22DD.
- Same-cycle bypass: wr_en=1, wr_sel=5, mask 4'b0011, wr_data=32'h12345678 while reg5=32'hFFFFFFFF and rd_sel1=5 -> rd_data1=32'hFFFF5678 in the same cycle; stored value matches on the next cycle.
- Scoreboard: iss_en with iss_sel=2, then rd_sel2=2, rd_en2=1 -> busy[2]=1 and hazard=1.
  - rd_en2=0 -> hazard=0.
  - Writeback to reg2 -> hazard=0 that cycle; busy[2]=0 on the next cycle.
- Simultaneous issue and writeback to reg6 -> busy[6] remains 1.
  - Issue on reg1 with writeback on reg4 -> busy[1]=1, busy[4]=0.
- VRF_ZERO_REG_EN defined: write 32'hDEADBEEF to reg0 and issue reg0 -> rd_data1=0, busy[0]=0, hazard=0.
